// File: rtl/prbs_checker_axis.sv
// rtl/prbs_checker_axis.sv - self-synchronising receive-side PRBS bit-error checker
//
// Ports:
//   clk, rst            : clock; asynchronous active-high reset
//   rx_bit, rx_valid    : received serial PRBS bit, one bit per rx_valid strobe
//   S_AXIS_PARAM_*      : parameter word, [7:5] polynomial select, [8] clear counters
//   M_AXIS_STAT_*       : status stream carrying err_count (always valid)
//   locked              : checker is in LOCKED
//   err_pulse           : one-cycle pulse per mismatching sample
//   bit_count/err_count : samples / error flags seen while LOCKED, saturating
module prbs_checker_axis #(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int PRBS_SEL         = 0,
    parameter int LOCK_COUNT       = 64,
    parameter int WINDOW           = 256,
    parameter int UNLOCK_ERRORS    = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rx_bit,
    input  logic                        rx_valid,
    input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_PARAM_tdata,
    input  logic                        S_AXIS_PARAM_tvalid,
    output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_STAT_tdata,
    output logic                        M_AXIS_STAT_tvalid,
    output logic                        locked,
    output logic                        err_pulse,
    output logic [31:0]                 bit_count,
    output logic [31:0]                 err_count
);

    typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_t;

    state_t      state, state_next;
    logic [30:0] s;
    logic [2:0]  sel;
    logic [4:0]  fill_cnt;
    logic [31:0] match_cnt;
    logic [31:0] win_cnt;
    logic [31:0] win_err;
    logic [31:0] bit_cnt;
    logic [31:0] err_cnt;

    logic [4:0]  tap_n, tap_m;
    logic        sel_ok;

    // Tap pair (n, m) for the selected polynomial x^n + x^m + 1.
    always_comb begin
        tap_n  = 5'd31;
        tap_m  = 5'd31;
        sel_ok = 1'b1;
        case (sel)
            3'd0:    begin tap_n = 5'd7;  tap_m = 5'd6;  end
            3'd1:    begin tap_n = 5'd9;  tap_m = 5'd5;  end
            3'd2:    begin tap_n = 5'd15; tap_m = 5'd14; end
            3'd3:    begin tap_n = 5'd23; tap_m = 5'd18; end
            3'd4:    begin tap_n = 5'd31; tap_m = 5'd28; end
            default: sel_ok = 1'b0;
        endcase
    end

    logic predicted, mismatch, fill_done, check, flag;
    logic sel_change, clear_req, lock_hit, unlock_hit;

    // A parameter word in the same cycle as a sample wins; the sample is dropped.
    assign sel_change = S_AXIS_PARAM_tvalid && (S_AXIS_PARAM_tdata[7:5] != sel);
    assign clear_req  = S_AXIS_PARAM_tvalid && S_AXIS_PARAM_tdata[8];
    assign predicted  = s[tap_n - 5'd1] ^ s[tap_m - 5'd1];
    assign mismatch   = rx_bit ^ predicted;
    assign fill_done  = (fill_cnt == tap_n);
    assign check      = rx_valid && !S_AXIS_PARAM_tvalid && fill_done && sel_ok;
    assign flag       = check && mismatch;
    assign lock_hit   = check && !mismatch && (state == SEARCH)
                        && (match_cnt == 32'(LOCK_COUNT - 1));
    assign unlock_hit = flag && (state == LOCKED)
                        && (win_err == 32'(UNLOCK_ERRORS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= SEARCH;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (sel_change) begin
            state_next = SEARCH;
        end else begin
            case (state)
                SEARCH:  if (lock_hit)   state_next = LOCKED;
                LOCKED:  if (unlock_hit) state_next = SEARCH;
                default: state_next = SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s         <= '0;
            sel       <= 3'(PRBS_SEL);
            fill_cnt  <= '0;
            match_cnt <= '0;
            win_cnt   <= '0;
            win_err   <= '0;
            bit_cnt   <= '0;
            err_cnt   <= '0;
            err_pulse <= 1'b0;
        end else begin
            err_pulse <= flag;
            if (S_AXIS_PARAM_tvalid) begin
                if (sel_change) begin
                    sel       <= S_AXIS_PARAM_tdata[7:5];
                    fill_cnt  <= '0;
                    match_cnt <= '0;
                    bit_cnt   <= '0;
                    err_cnt   <= '0;
                end
                if (clear_req) begin
                    bit_cnt <= '0;
                    err_cnt <= '0;
                end
            end else if (rx_valid) begin
                // Received bits (errors included) feed the predictor, which is
                // what makes the checker self-synchronising.
                s <= {s[29:0], rx_bit};
                if (!fill_done) fill_cnt <= fill_cnt + 5'd1;
                if (check) begin
                    if (state == SEARCH) begin
                        if (mismatch) begin
                            match_cnt <= '0;
                        end else if (lock_hit) begin
                            match_cnt <= '0;
                            bit_cnt   <= '0;
                            err_cnt   <= '0;
                            win_cnt   <= '0;
                            win_err   <= '0;
                        end else begin
                            match_cnt <= match_cnt + 32'd1;
                        end
                    end else begin
                        if (bit_cnt != '1) bit_cnt <= bit_cnt + 32'd1;
                        if (mismatch && err_cnt != '1) err_cnt <= err_cnt + 32'd1;
                        if (unlock_hit) match_cnt <= '0;
                        if (win_cnt == 32'(WINDOW - 1)) begin
                            win_cnt <= '0;
                            win_err <= '0;
                        end else begin
                            win_cnt <= win_cnt + 32'd1;
                            if (mismatch) win_err <= win_err + 32'd1;
                        end
                    end
                end
            end
        end
    end

    logic unused_param_bits;
    assign unused_param_bits = ^{S_AXIS_PARAM_tdata[AXIS_TDATA_WIDTH-1:9],
                                 S_AXIS_PARAM_tdata[4:0]};

    assign locked             = (state == LOCKED);
    assign bit_count          = bit_cnt;
    assign err_count          = err_cnt;
    assign M_AXIS_STAT_tdata  = AXIS_TDATA_WIDTH'(err_cnt);
    assign M_AXIS_STAT_tvalid = 1'b1;

endmodule

// File: tb/tb_prbs_checker_axis.sv
// tb/tb_prbs_checker_axis.sv - directed self-checking bench for prbs_checker_axis
module tb_prbs_checker_axis;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_bit = 1'b0;
    logic        rx_valid = 1'b0;
    logic [31:0] param_tdata = '0;
    logic        param_tvalid = 1'b0;
    logic [31:0] stat_tdata;
    logic        stat_tvalid;
    logic        locked;
    logic        err_pulse;
    logic [31:0] bit_count;
    logic [31:0] err_count;

    int total = 0;
    int bad = 0;

    prbs_checker_axis dut (
        .clk                 (clk),
        .rst                 (rst),
        .rx_bit              (rx_bit),
        .rx_valid            (rx_valid),
        .S_AXIS_PARAM_tdata  (param_tdata),
        .S_AXIS_PARAM_tvalid (param_tvalid),
        .M_AXIS_STAT_tdata   (stat_tdata),
        .M_AXIS_STAT_tvalid  (stat_tvalid),
        .locked              (locked),
        .err_pulse           (err_pulse),
        .bit_count           (bit_count),
        .err_count           (err_count)
    );

    always #5 clk = ~clk;

    // Transmit-side PRBS generator model (stimulus source).
    logic [30:0] g;
    int          gn, gm;
    int          pulses;
    logic        locked_seen;

    task automatic set_poly(input int n, input int m);
        gn = n;
        gm = m;
        g  = '1;
    endtask

    task automatic next_bit(output logic b);
        b = g[gn-1] ^ g[gm-1];
        g = {g[29:0], b};
    endtask

    // Called and returning at a negedge; outputs observed half a cycle after the edge.
    task automatic send_bit(input logic b, input int gap);
        rx_bit   = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        if (err_pulse) pulses++;
        if (locked) locked_seen = 1'b1;
        repeat (gap - 1) @(negedge clk);
    endtask

    task automatic send_clean(input int count, input int gap);
        logic b;
        for (int i = 0; i < count; i++) begin
            next_bit(b);
            send_bit(b, gap);
        end
    endtask

    task automatic send_error(input int gap);
        logic b;
        next_bit(b);
        send_bit(~b, gap);
    endtask

    task automatic param_write(input logic [31:0] data, input logic with_sample);
        param_tdata  = data;
        param_tvalid = 1'b1;
        rx_valid     = with_sample;
        rx_bit       = 1'b1;
        @(negedge clk);
        param_tvalid = 1'b0;
        rx_valid     = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL reset_locked got=%0b want=0", locked); end
        total++; if (err_pulse !== 1'b0) begin bad++; $display("FAIL reset_err_pulse got=%0b want=0", err_pulse); end
        total++; if (bit_count !== 32'd0) begin bad++; $display("FAIL reset_bit_count got=%0d want=0", bit_count); end
        total++; if (err_count !== 32'd0) begin bad++; $display("FAIL reset_err_count got=%0d want=0", err_count); end
        total++; if (stat_tdata !== 32'd0) begin bad++; $display("FAIL reset_tdata got=%0h want=0", stat_tdata); end
        total++; if (stat_tvalid !== 1'b1) begin bad++; $display("FAIL reset_tvalid got=%0b want=1", stat_tvalid); end
    endtask

    task automatic test_prbs7_lock();
        set_poly(7, 6);
        pulses = 0;
        send_clean(70, 4);
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL p7_not_yet_locked got=%0b want=0", locked); end
        send_clean(1, 4);
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL p7_locked_at_71 got=%0b want=1", locked); end
        send_clean(1000, 4);
        total++; if (bit_count !== 32'd1000) begin bad++; $display("FAIL p7_bit_count got=%0d want=1000", bit_count); end
        total++; if (err_count !== 32'd0) begin bad++; $display("FAIL p7_err_count got=%0d want=0", err_count); end
        total++; if (pulses !== 0) begin bad++; $display("FAIL p7_no_pulses got=%0d want=0", pulses); end
    endtask

    task automatic test_back_to_back();
        send_clean(500, 1);
        total++; if (bit_count !== 32'd1500) begin bad++; $display("FAIL b2b_bit_count got=%0d want=1500", bit_count); end
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL b2b_locked got=%0b want=1", locked); end
    endtask

    task automatic test_single_error();
        param_write(32'h40, 1'b0);
        set_poly(15, 14);
        send_clean(79, 1);
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL p15_locked got=%0b want=1", locked); end
        pulses = 0;
        send_error(1);
        send_clean(40, 1);
        total++; if (pulses !== 3) begin bad++; $display("FAIL p15_pulses got=%0d want=3", pulses); end
        total++; if (err_count !== 32'd3) begin bad++; $display("FAIL p15_err_count got=%0d want=3", err_count); end
        total++; if (bit_count !== 32'd41) begin bad++; $display("FAIL p15_bit_count got=%0d want=41", bit_count); end
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL p15_still_locked got=%0b want=1", locked); end
    endtask

    task automatic test_burst_unlock();
        param_write(32'h80, 1'b0);
        set_poly(31, 28);
        send_clean(95, 1);
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL p31_locked got=%0b want=1", locked); end
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            send_error(1);
            send_clean(31, 1);
        end
        total++; if (pulses !== 15) begin bad++; $display("FAIL p31_pulses15 got=%0d want=15", pulses); end
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL p31_locked_at_15 got=%0b want=1", locked); end
        send_error(1);
        total++; if (err_pulse !== 1'b1) begin bad++; $display("FAIL p31_flag16 got=%0b want=1", err_pulse); end
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL p31_unlock got=%0b want=0", locked); end
        total++; if (err_count !== 32'd16) begin bad++; $display("FAIL p31_err16 got=%0d want=16", err_count); end
        send_clean(31, 1);
        total++; if (pulses !== 18) begin bad++; $display("FAIL p31_pulses18 got=%0d want=18", pulses); end
        total++; if (err_count !== 32'd16) begin bad++; $display("FAIL p31_err_held got=%0d want=16", err_count); end
        total++; if (bit_count !== 32'd161) begin bad++; $display("FAIL p31_bits_held got=%0d want=161", bit_count); end
        send_clean(63, 1);
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL p31_relock_early got=%0b want=0", locked); end
        send_clean(1, 1);
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL p31_relock got=%0b want=1", locked); end
        total++; if (bit_count !== 32'd0) begin bad++; $display("FAIL p31_relock_bits got=%0d want=0", bit_count); end
        total++; if (err_count !== 32'd0) begin bad++; $display("FAIL p31_relock_errs got=%0d want=0", err_count); end
    endtask

    task automatic test_param_change();
        param_write(32'h20, 1'b0);
        set_poly(9, 5);
        send_clean(73, 1);
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL p9_locked got=%0b want=1", locked); end
        send_clean(10, 1);
        total++; if (bit_count !== 32'd10) begin bad++; $display("FAIL p9_bits got=%0d want=10", bit_count); end
        param_write(32'h60, 1'b1);
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL sel_change_locked got=%0b want=0", locked); end
        total++; if (bit_count !== 32'd0) begin bad++; $display("FAIL sel_change_bits got=%0d want=0", bit_count); end
        total++; if (err_count !== 32'd0) begin bad++; $display("FAIL sel_change_errs got=%0d want=0", err_count); end
        set_poly(23, 18);
        send_clean(86, 1);
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL p23_early got=%0b want=0", locked); end
        send_clean(1, 1);
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL p23_locked got=%0b want=1", locked); end
        send_clean(5, 1);
        param_write(32'h160, 1'b0);
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL clear_locked got=%0b want=1", locked); end
        total++; if (bit_count !== 32'd0) begin bad++; $display("FAIL clear_bits got=%0d want=0", bit_count); end
        send_clean(3, 1);
        total++; if (bit_count !== 32'd3) begin bad++; $display("FAIL clear_recount got=%0d want=3", bit_count); end
    endtask

    task automatic test_invalid_sel();
        param_write(32'hC0, 1'b0);
        set_poly(7, 6);
        locked_seen = 1'b0;
        send_clean(10000, 1);
        total++; if (locked_seen !== 1'b0) begin bad++; $display("FAIL invalid_sel_locked got=%0b want=0", locked_seen); end
    endtask

    task automatic test_saturation();
        do_reset();
        set_poly(7, 6);
        send_clean(71, 1);
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL sat_locked got=%0b want=1", locked); end
        dut.err_cnt = 32'hFFFF_FFFE;
        pulses = 0;
        send_error(1);
        total++; if (err_count !== 32'hFFFF_FFFF) begin bad++; $display("FAIL sat_err_count got=%0h want=ffffffff", err_count); end
        send_clean(10, 1);
        total++; if (err_count !== 32'hFFFF_FFFF) begin bad++; $display("FAIL sat_err_hold got=%0h want=ffffffff", err_count); end
        total++; if (stat_tdata !== 32'hFFFF_FFFF) begin bad++; $display("FAIL sat_tdata got=%0h want=ffffffff", stat_tdata); end
        total++; if (pulses !== 3) begin bad++; $display("FAIL sat_pulses got=%0d want=3", pulses); end
    endtask

    task automatic test_async_reset();
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL areset_pre_locked got=%0b want=1", locked); end
        #2 rst = 1'b1;
        #1;
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL areset_locked got=%0b want=0", locked); end
        total++; if (err_count !== 32'd0) begin bad++; $display("FAIL areset_err_count got=%0h want=0", err_count); end
        total++; if (bit_count !== 32'd0) begin bad++; $display("FAIL areset_bit_count got=%0d want=0", bit_count); end
        total++; if (stat_tdata !== 32'd0) begin bad++; $display("FAIL areset_tdata got=%0h want=0", stat_tdata); end
        total++; if (stat_tvalid !== 1'b1) begin bad++; $display("FAIL areset_tvalid got=%0b want=1", stat_tvalid); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        pulses      = 0;
        locked_seen = 1'b0;
        set_poly(7, 6);
        test_reset();
        test_prbs7_lock();
        test_back_to_back();
        test_single_error();
        test_burst_unlock();
        test_param_change();
        test_invalid_sel();
        test_saturation();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
